// File: rtl/mem_bus_defs.sv
// Shared definitions for the memory bus responder:
// FSM state encoding and wait-counter width.
package mem_bus_defs;

  typedef enum logic [1:0] {
    S_Idle   = 2'd0,
    S_Wait   = 2'd1,
    S_Access = 2'd2,
    S_Ack    = 2'd3
  } state_e;

  localparam int CntWidth = 4;

endpackage

// File: rtl/mem_bus_wait_counter.sv
// Loadable down-counter for wait states; last flags cnt == 1.
// Saturates at zero when decremented while empty.
module mem_bus_wait_counter
  import mem_bus_defs::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CntWidth-1:0] load_val,
  input  logic                dec,
  output logic                last
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CntWidth'(1));

endmodule

// File: rtl/mem_bus_responder.sv
// 4-phase Req/Ack memory responder with programmable wait states.
// Optional write protection of low addresses: MEM_WRITE_PROTECT_EN.
module mem_bus_responder
  import mem_bus_defs::*;
#(
  parameter int DataWidth    = 16,
  parameter int AddrWidth    = 8,
  parameter int WaitCycles   = 2,
  parameter int ProtectLimit = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Req,
  input  logic                 WrEn,
  input  logic [AddrWidth-1:0] Addr,
  input  logic [DataWidth-1:0] DataIn,
  output logic [DataWidth-1:0] DataOut,
  output logic                 Ack,
  output logic                 Busy,
  output logic                 Fault
);

  localparam int Depth = 2 ** AddrWidth;
  localparam int AwExt = AddrWidth + 1;
  localparam logic [CntWidth-1:0] WaitLd =
    CntWidth'(WaitCycles);
  localparam logic [AwExt-1:0] PLim =
    AwExt'(ProtectLimit);

  state_e state_q, state_d;

  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 wr_q, wr_d;
  logic [DataWidth-1:0] din_q, din_d;
  logic [DataWidth-1:0] dout_q, dout_d;
  logic                 ack_q, ack_d;
  logic                 fault_q, fault_d;

  logic [DataWidth-1:0] mem [Depth];

  logic cnt_load, cnt_dec, cnt_last;
  logic mem_we, prot_hit, prot_blk;

  assign cnt_load = (state_q == S_Idle) && Req;
  assign cnt_dec  = (state_q == S_Wait);

  mem_bus_wait_counter u_cnt (
    .clk      (Clk),
    .rst      (Reset),
    .load     (cnt_load),
    .load_val (WaitLd),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  assign prot_hit = ({1'b0, addr_q} < PLim);

`ifdef MEM_WRITE_PROTECT_EN
  assign prot_blk = prot_hit;
`else
  logic unused_prot;
  assign unused_prot = prot_hit;
  assign prot_blk    = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_Idle;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      fault_q <= fault_d;
    end
  end

  // Contents survive reset; only the access edge writes.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[addr_q] <= din_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_Idle: begin
        if (Req) begin
          state_d = (WaitCycles == 0) ? S_Access : S_Wait;
        end
      end
      S_Wait: begin
        if (cnt_last) begin
          state_d = S_Access;
        end
      end
      S_Access: state_d = S_Ack;
      S_Ack: begin
        if (!Req) begin
          state_d = S_Idle;
        end
      end
      default: state_d = S_Idle;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wr_d    = wr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    ack_d   = ack_q;
    fault_d = 1'b0;
    mem_we  = 1'b0;
    Busy    = (state_q != S_Idle);
    if (cnt_load) begin
      addr_d = Addr;
      wr_d   = WrEn;
      din_d  = DataIn;
    end
    unique case (state_q)
      S_Access: begin
        ack_d = 1'b1;
        if (wr_q) begin
          mem_we  = !prot_blk;
          fault_d = prot_blk;
        end else begin
          dout_d = mem[addr_q];
        end
      end
      S_Ack: begin
        if (!Req) begin
          ack_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign DataOut = dout_q;
  assign Ack     = ack_q;
  assign Fault   = fault_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: vector table, corner sequences,
// random traffic against a word-array reference model.
module tb_mem_bus_responder;
  import mem_bus_defs::*;

  localparam int W = 2;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        Clk, Reset;
  logic        Req, WrEn;
  logic [7:0]  Addr;
  logic [15:0] DataIn, DataOut;
  logic        Ack, Busy, Fault;

  logic        Req0, WrEn0;
  logic [7:0]  Addr0;
  logic [15:0] DataIn0, DataOut0;
  logic        Ack0, Busy0, Fault0;

  int total = 0;
  int bad   = 0;

  logic [15:0] ref_mem [256];
  bit          known   [256];

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
    bit          scr;
    int          hold;
  } vec_t;

  vec_t tbl [16];
  int   ntbl = 0;

  mem_bus_responder #(.WaitCycles(W)) u_dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WrEn(WrEn),
    .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut),
    .Ack(Ack), .Busy(Busy), .Fault(Fault)
  );

  mem_bus_responder #(.WaitCycles(0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Req(Req0), .WrEn(WrEn0),
    .Addr(Addr0), .DataIn(DataIn0), .DataOut(DataOut0),
    .Ack(Ack0), .Busy(Busy0), .Fault(Fault0)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One full handshake on u_dut; caller sits at a negedge, DUT idle.
  task automatic txn(input logic wr, input logic [7:0] a,
                     input logic [15:0] d, input bit scr,
                     input int hold, output logic [15:0] rd);
    int k;
    bit got;
    bit exp_f;
    exp_f  = PROT && wr && (a < 8'd8);
    Req    = 1'b1;
    WrEn   = wr;
    Addr   = a;
    DataIn = d;
    got    = 1'b0;
    rd     = '0;
    for (k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (scr && k == 1) begin
        Addr   = ~a;
        DataIn = ~d;
      end
      if (Ack) begin
        got = 1'b1;
        break;
      end
      if (Fault) chk("fault_early", 32'(Fault), 0);
      if (!Busy) chk("busy_wait", 32'(Busy), 1);
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      Req = 1'b0;
      @(negedge Clk);
      return;
    end
    chk("latency", 32'(k - 1), 32'(W + 1));
    chk("fault_at_ack", 32'(Fault), 32'(exp_f));
    rd = DataOut;
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      chk("ack_hold", 32'(Ack), 1);
      chk("busy_hold", 32'(Busy), 1);
      chk("fault_hold", 32'(Fault), 0);
      chk("dout_hold", 32'(DataOut), 32'(rd));
    end
    Req = 1'b0;
    @(negedge Clk);
    chk("ack_fall", 32'(Ack), 0);
    chk("busy_idle", 32'(Busy), 0);
  endtask

  // Transaction plus reference-model update and data check.
  task automatic apply(input logic wr, input logic [7:0] a,
                       input logic [15:0] d, input bit scr,
                       input int hold, input bit has_exp,
                       input logic [15:0] exp);
    logic [15:0] rd;
    bit locked;
    locked = PROT && (a < 8'd8);
    txn(wr, a, d, scr, hold, rd);
    if (wr) begin
      if (!locked) begin
        ref_mem[a] = d;
        known[a]   = 1'b1;
      end
    end else if (has_exp && !locked) begin
      chk("tbl_rd", 32'(rd), 32'(exp));
    end else if (known[a]) begin
      chk("model_rd", 32'(rd), 32'(ref_mem[a]));
    end else begin
      ref_mem[a] = rd;
      known[a]   = 1'b1;
    end
  endtask

  task automatic add(input logic wr, input logic [7:0] a,
                     input logic [15:0] d, input logic [15:0] exp,
                     input bit scr, input int hold);
    tbl[ntbl].wr   = wr;
    tbl[ntbl].a    = a;
    tbl[ntbl].d    = d;
    tbl[ntbl].exp  = exp;
    tbl[ntbl].scr  = scr;
    tbl[ntbl].hold = hold;
    ntbl++;
  endtask

  task automatic txn0(input logic wr, input logic [7:0] a,
                      input logic [15:0] d, output logic [15:0] rd);
    int k;
    bit got;
    Req0    = 1'b1;
    WrEn0   = wr;
    Addr0   = a;
    DataIn0 = d;
    got     = 1'b0;
    rd      = '0;
    for (k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (Ack0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("w0_timeout", 0, 1);
    end else begin
      chk("w0_latency", 32'(k - 1), 1);
      rd = DataOut0;
    end
    Req0 = 1'b0;
    @(negedge Clk);
    chk("w0_ack_fall", 32'(Ack0), 0);
  endtask

  initial begin
    logic [15:0] rd;
    int acks;
    logic [15:0] seen;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      known[i]   = 1'b0;
    end
    Reset = 1'b1;
    Req = 1'b0; WrEn = 1'b0; Addr = '0; DataIn = '0;
    Req0 = 1'b0; WrEn0 = 1'b0; Addr0 = '0; DataIn0 = '0;

    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_ack", 32'(Ack), 0);
    chk("rst_dout", 32'(DataOut), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_fault", 32'(Fault), 0);
    chk("rst_state", 32'(u_dut.state_q), 32'(S_Idle));

    add(1'b1, 8'h03, 16'hBEEF, 16'h0000, 1'b0, 0);
    add(1'b0, 8'h03, 16'h0000, 16'hBEEF, 1'b0, 0);
    add(1'b1, 8'h20, 16'h1234, 16'h0000, 1'b0, 0);
    add(1'b0, 8'h20, 16'h0000, 16'h1234, 1'b0, 0);
    add(1'b1, 8'h30, 16'h0000, 16'h0000, 1'b0, 0);
    add(1'b0, 8'h30, 16'hFFFF, 16'h0000, 1'b0, 1);
    add(1'b1, 8'hFF, 16'hA5A5, 16'h0000, 1'b1, 0);
    add(1'b0, 8'hFF, 16'h0000, 16'hA5A5, 1'b1, 2);
    add(1'b1, 8'h00, 16'h0F0F, 16'h0000, 1'b0, 0);
    add(1'b0, 8'h00, 16'h0000, 16'h0F0F, 1'b0, 0);
    add(1'b1, 8'h02, 16'h00AA, 16'h0000, 1'b0, 0);
    add(1'b0, 8'h02, 16'h0000, 16'h00AA, 1'b0, 0);
    add(1'b1, 8'h02, 16'hFFFF, 16'h0000, 1'b0, 0);
    add(1'b0, 8'h02, 16'h0000, 16'hFFFF, 1'b0, 0);
    add(1'b0, 8'h03, 16'h0000, 16'hBEEF, 1'b0, 3);

    for (int i = 0; i < ntbl; i++) begin
      apply(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].scr,
            tbl[i].hold, 1'b1, tbl[i].exp);
    end

    txn0(1'b1, 8'h20, 16'h1234, rd);
    txn0(1'b0, 8'h20, 16'h0000, rd);
    chk("w0_rd", 32'(rd), 32'h1234);

    // Reset while the write to 0x30 waits.
    Req = 1'b1; WrEn = 1'b1; Addr = 8'h30; DataIn = 16'hBBBB;
    @(negedge Clk);
    chk("mid_state_wait", 32'(u_dut.state_q), 32'(S_Wait));
    Reset = 1'b1;
    #1;
    chk("mid_state_rst", 32'(u_dut.state_q), 32'(S_Idle));
    chk("mid_ack_rst", 32'(Ack), 0);
    @(negedge Clk);
    Reset = 1'b0;
    Req   = 1'b0;
    @(negedge Clk);
    chk("mid_ack", 32'(Ack), 0);
    chk("mid_busy", 32'(Busy), 0);
    chk("mid_state", 32'(u_dut.state_q), 32'(S_Idle));
    apply(1'b0, 8'h30, 16'h0000, 1'b0, 0, 1'b1, 16'h0000);

    // Req withdrawn during the wait phase.
    Req = 1'b1; WrEn = 1'b0; Addr = 8'h20;
    @(negedge Clk);
    Req  = 1'b0;
    acks = 0;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (Ack) begin
        acks++;
        seen = DataOut;
      end
    end
    chk("drop_ack_cycles", 32'(acks), 1);
    chk("drop_rd", 32'(seen), 32'h1234);
    chk("drop_busy", 32'(Busy), 0);

    for (int i = 0; i < 80; i++) begin
      logic        wr;
      logic [7:0]  a;
      logic [15:0] d;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 9));
      else a = 8'($urandom_range(0, 255));
      d = 16'($urandom);
      apply(wr, a, d, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), 1'b0, 16'h0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
